// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit: default widths, the
// reset PC, the NOP used for faulted fetches and the fetch FSM states.
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int          IFU_XLEN     = 64;
    localparam int          IFU_BUS_W    = 64;
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    // addi x0, x0, 0 -- handed to decode in place of a word that faulted
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// ---------------------------------------------------------------------------
// ifu_if
// Bundles the fetch unit's read bus (AR/R channels, AXI-lite style) and its
// valid/ready instruction channel toward decode.
//   master : the fetch unit (drives araddr/arvalid/rready and out_*)
//   slave  : memory plus decode (drives arready, r*, out_ready)
// ---------------------------------------------------------------------------
interface ifu_if
    import ifu_pkg::*;
#(
    parameter int XLEN  = IFU_XLEN,
    parameter int BUS_W = IFU_BUS_W
);

    logic [XLEN-1:0]  araddr;
    logic             arvalid;
    logic             arready;
    logic [BUS_W-1:0] rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_inst;
    logic             out_fault;

    modport master (
        output araddr, arvalid, rready,
        output out_valid, out_pc, out_inst, out_fault,
        input  arready, rdata, rresp, rvalid,
        input  out_ready
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  out_valid, out_pc, out_inst, out_fault,
        output arready, rdata, rresp, rvalid,
        output out_ready
    );

endinterface

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit
// Owns the PC, issues one read per instruction on the read bus (single
// outstanding request) and presents {pc, inst, fault} to decode. Redirects
// from execute/CSR replace the fetch stream; a response that belongs to a
// request issued before a redirect is dropped using a one-bit flush flag.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   redirect_valid/pc   one-cycle redirect pulse and target (bits [1:0] ignored)
//   bus (ifu_if.master) read bus + decode handshake; all outputs registered
// ---------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter int              BUS_W    = IFU_BUS_W,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    ifu_if.master           bus
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            load_out;
    logic            clear_out;

    logic [XLEN-1:0] araddr_q;
    logic            arvalid_q;
    logic            rready_q;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [31:0]     out_inst_q;
    logic            out_fault_q;

    logic            ar_fire;
    logic            r_fire;
    logic            rsp_fault;
    logic [31:0]     inst_word;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_bits;

    assign ar_fire              = arvalid_q & bus.arready;
    assign r_fire               = rready_q & bus.rvalid;
    assign rsp_fault            = (bus.rresp != 2'b00);
    assign inst_word            = pc_q[2] ? bus.rdata[BUS_W-1 -: 32] : bus.rdata[31:0];
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // State, PC and flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    // Next-state logic. A redirect always updates the PC immediately; the
    // request already on the bus (or about to be) cannot be recalled, so its
    // response is marked stale via flush and thrown away when it arrives.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_d   = flush_q;
        load_out  = 1'b0;
        clear_out = 1'b0;
        case (state_q)
            S_REQ: begin
                if (ar_fire) begin
                    state_d = S_WAIT;
                end
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    flush_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    flush_d = 1'b1;
                end
                if (r_fire) begin
                    if (flush_q || redirect_valid) begin
                        flush_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        load_out = 1'b1;
                        state_d  = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d      = redirect_target;
                    clear_out = 1'b1;
                    state_d   = S_REQ;
                end else if (bus.out_ready) begin
                    pc_d      = pc_q + XLEN'(4);
                    clear_out = 1'b1;
                    state_d   = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Bus-side registers. The address is captured only on entry to S_REQ so
    // that a redirect during a pending request leaves araddr untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= {RESET_PC[XLEN-1:3], 3'b000};
        end else begin
            arvalid_q <= (state_d == S_REQ);
            rready_q  <= (state_d == S_WAIT);
            if ((state_q != S_REQ) && (state_d == S_REQ)) begin
                araddr_q <= {pc_d[XLEN-1:3], 3'b000};
            end
        end
    end

    // Decode-side pipeline register; a faulted fetch carries a NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_inst_q  <= 32'h0;
            out_fault_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= pc_q;
            out_inst_q  <= rsp_fault ? INST_NOP : inst_word;
            out_fault_q <= rsp_fault;
        end else if (clear_out) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.araddr    = araddr_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_fault = out_fault_q;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu
// Directed bench for the fetch unit. A small memory model answers reads with
// low word = addr ^ 32'hDEAD_0000 and high word = (addr + 4) ^ 32'hDEAD_0000,
// so the instruction fetched at pc is pc[31:0] ^ 32'hDEAD_0000.
// ---------------------------------------------------------------------------
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;

    int tests_run    = 0;
    int tests_failed = 0;

    // memory model configuration, written by the stimulus process
    int          rdelay   = 0;
    logic [1:0]  resp_cfg = 2'b00;

    // memory model state
    bit          pend = 1'b0;
    int          cnt = 0;
    bit          ar_fire_prev = 1'b0;
    bit          r_fire_prev = 1'b0;
    logic [63:0] ar_addr_prev = 64'h0;
    logic [63:0] pend_addr = 64'h0;

    // observed bus and decode handshakes
    logic [63:0] obs_ar[$];
    logic [63:0] obs_pc[$];
    logic [63:0] obs_inst[$];
    logic [63:0] obs_fault[$];
    int          obs_cyc[$];
    int          cycle = 0;

    ifu_if #(.XLEN(64), .BUS_W(64)) bus_if ();

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    // Memory responder: at each falling edge it acts on the handshakes that
    // happened at the previous rising edge and sets up the next response.
    always @(negedge clk) begin
        if (rst) begin
            bus_if.rvalid = 1'b0;
            bus_if.rdata  = 64'h0;
            bus_if.rresp  = 2'b00;
            pend          = 1'b0;
            ar_fire_prev  = 1'b0;
            r_fire_prev   = 1'b0;
        end else begin
            if (r_fire_prev) begin
                bus_if.rvalid = 1'b0;
            end
            if (ar_fire_prev) begin
                pend      = 1'b1;
                pend_addr = ar_addr_prev;
                cnt       = rdelay;
            end
            if (pend && !bus_if.rvalid) begin
                if (cnt == 0) begin
                    bus_if.rvalid = 1'b1;
                    bus_if.rdata  = {(pend_addr[31:0] + 32'd4) ^ 32'hDEAD_0000,
                                     pend_addr[31:0] ^ 32'hDEAD_0000};
                    bus_if.rresp  = resp_cfg;
                    pend          = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            ar_fire_prev = bus_if.arvalid && bus_if.arready;
            ar_addr_prev = bus_if.araddr;
            r_fire_prev  = bus_if.rvalid && bus_if.rready;
        end
    end

    // Handshake monitor; an instruction shown in a redirect cycle is squashed
    // and therefore not counted as consumed.
    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            if (bus_if.arvalid && bus_if.arready) begin
                obs_ar.push_back(bus_if.araddr);
            end
            if (bus_if.out_valid && bus_if.out_ready && !redirect_valid) begin
                obs_pc.push_back(bus_if.out_pc);
                obs_inst.push_back(64'(bus_if.out_inst));
                obs_fault.push_back(64'(bus_if.out_fault));
                obs_cyc.push_back(cycle);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic ordy);
        redirect_valid   = rv;
        redirect_pc      = rpc;
        bus_if.out_ready = ordy;
        tick();
        redirect_valid   = 1'b0;
    endtask

    task automatic clearObs();
        obs_ar.delete();
        obs_pc.delete();
        obs_inst.delete();
        obs_fault.delete();
        obs_cyc.delete();
    endtask

    function automatic logic [63:0] qAt(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic int cycAt(input int i);
        if (i < obs_cyc.size()) return obs_cyc[i];
        return -1000;
    endfunction

    task automatic waitConsumes(input int n, input string tag);
        int budget = 80;
        while (obs_pc.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        if (obs_pc.size() < n) checkOutput(tag, 64'(obs_pc.size()), 64'(n));
    endtask

    function automatic logic sigSel(input int sel);
        case (sel)
            0:       return bus_if.arvalid;
            1:       return bus_if.rready;
            default: return bus_if.out_valid;
        endcase
    endfunction

    task automatic waitCond(input int sel, input string tag);
        int budget = 80;
        while (sigSel(sel) !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (sigSel(sel) !== 1'b1) checkOutput(tag, 64'(sigSel(sel)), 64'd1);
    endtask

    // Global time bound.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_if.arready   = 1'b1;
        bus_if.out_ready = 1'b1;

        // Reset values while reset is held
        tick();
        tick();
        checkOutput("rst_arvalid",   64'(bus_if.arvalid),   64'd0);
        checkOutput("rst_rready",    64'(bus_if.rready),    64'd0);
        checkOutput("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        checkOutput("rst_out_pc",    bus_if.out_pc,         64'h8000_0000);
        checkOutput("rst_out_inst",  64'(bus_if.out_inst),  64'd0);
        checkOutput("rst_out_fault", 64'(bus_if.out_fault), 64'd0);

        // 1: sequential fetch, zero-wait memory, decode always ready
        rst = 1'b0;
        waitConsumes(3, "t1_timeout");
        checkOutput("t1_ar0",   qAt(obs_ar, 0),   64'h8000_0000);
        checkOutput("t1_ar1",   qAt(obs_ar, 1),   64'h8000_0000);
        checkOutput("t1_ar2",   qAt(obs_ar, 2),   64'h8000_0008);
        checkOutput("t1_pc0",   qAt(obs_pc, 0),   64'h8000_0000);
        checkOutput("t1_pc1",   qAt(obs_pc, 1),   64'h8000_0004);
        checkOutput("t1_pc2",   qAt(obs_pc, 2),   64'h8000_0008);
        checkOutput("t1_inst0", qAt(obs_inst, 0), 64'h5EAD_0000);
        checkOutput("t1_inst1", qAt(obs_inst, 1), 64'h5EAD_0004);
        checkOutput("t1_inst2", qAt(obs_inst, 2), 64'h5EAD_0008);
        checkOutput("t1_lat01", 64'(cycAt(1) - cycAt(0)), 64'd3);
        checkOutput("t1_lat12", 64'(cycAt(2) - cycAt(1)), 64'd3);

        // 2: decode stalls for 5 cycles
        bus_if.out_ready = 1'b0;
        waitCond(2, "t2_wait_valid");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_valid",   64'(bus_if.out_valid), 64'd1);
            checkOutput("t2_pc",      bus_if.out_pc,         64'h8000_000C);
            checkOutput("t2_inst",    64'(bus_if.out_inst),  64'h5EAD_000C);
            checkOutput("t2_arvalid", 64'(bus_if.arvalid),   64'd0);
            tick();
        end

        // 3: redirect while waiting on a slow response
        rdelay = 3;
        applyStimulus(1'b0, 64'h0, 1'b1);
        clearObs();
        waitCond(1, "t3_wait_rready");
        applyStimulus(1'b1, 64'h8000_0100, 1'b1);
        waitConsumes(1, "t3_timeout");
        checkOutput("t3_ar_old",  qAt(obs_ar, 0),   64'h8000_0010);
        checkOutput("t3_ar_new",  qAt(obs_ar, 1),   64'h8000_0100);
        checkOutput("t3_pc",      qAt(obs_pc, 0),   64'h8000_0100);
        checkOutput("t3_inst",    qAt(obs_inst, 0), 64'h5EAD_0100);

        // 4: redirect while the read request is stuck (arready low)
        bus_if.arready   = 1'b0;
        bus_if.out_ready = 1'b0;
        rdelay           = 0;
        waitCond(0, "t4_wait_arvalid");
        clearObs();
        applyStimulus(1'b1, 64'h8000_0200, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("t4_araddr_hold",  bus_if.araddr,        64'h8000_0100);
            checkOutput("t4_arvalid_hold", 64'(bus_if.arvalid),  64'd1);
            tick();
        end
        bus_if.arready   = 1'b1;
        bus_if.out_ready = 1'b1;
        waitConsumes(1, "t4_timeout");
        checkOutput("t4_ar_old", qAt(obs_ar, 0),   64'h8000_0100);
        checkOutput("t4_ar_new", qAt(obs_ar, 1),   64'h8000_0200);
        checkOutput("t4_pc",     qAt(obs_pc, 0),   64'h8000_0200);
        checkOutput("t4_inst",   qAt(obs_inst, 0), 64'h5EAD_0200);

        // 5: bus error response, then fetch continues at pc+4
        resp_cfg = 2'b10;
        clearObs();
        waitConsumes(1, "t5_timeout_a");
        resp_cfg = 2'b00;
        checkOutput("t5_fault_pc",   qAt(obs_pc, 0),    64'h8000_0204);
        checkOutput("t5_fault_flag", qAt(obs_fault, 0), 64'd1);
        checkOutput("t5_fault_inst", qAt(obs_inst, 0),  64'h0000_0013);
        waitConsumes(2, "t5_timeout_b");
        checkOutput("t5_next_pc",    qAt(obs_pc, 1),    64'h8000_0208);
        checkOutput("t5_next_fault", qAt(obs_fault, 1), 64'd0);
        checkOutput("t5_next_inst",  qAt(obs_inst, 1),  64'h5EAD_0208);

        // 6a: redirect and out_ready together in S_OUT squash the instruction
        bus_if.out_ready = 1'b0;
        waitCond(2, "t6_wait_valid");
        checkOutput("t6_held_pc", bus_if.out_pc, 64'h8000_020C);
        clearObs();
        applyStimulus(1'b1, 64'h8000_0300, 1'b1);
        checkOutput("t6_squash_valid", 64'(bus_if.out_valid), 64'd0);
        waitConsumes(1, "t6_timeout");
        checkOutput("t6_ar",   qAt(obs_ar, 0),   64'h8000_0300);
        checkOutput("t6_pc",   qAt(obs_pc, 0),   64'h8000_0300);
        checkOutput("t6_inst", qAt(obs_inst, 0), 64'h5EAD_0300);

        // Redirect in the request handshake cycle, unaligned target, pc wrap
        clearObs();
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        waitConsumes(2, "wrap_timeout");
        checkOutput("wrap_ar_drop", qAt(obs_ar, 0),   64'h8000_0300);
        checkOutput("wrap_ar_top",  qAt(obs_ar, 1),   64'hFFFF_FFFF_FFFF_FFF8);
        checkOutput("wrap_ar_zero", qAt(obs_ar, 2),   64'h0);
        checkOutput("wrap_pc0",     qAt(obs_pc, 0),   64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_inst0",   qAt(obs_inst, 0), 64'h2152_FFFC);
        checkOutput("wrap_pc1",     qAt(obs_pc, 1),   64'h0);
        checkOutput("wrap_inst1",   qAt(obs_inst, 1), 64'hDEAD_0000);

        // 6b: asynchronous reset while waiting for a response
        rdelay = 3;
        waitCond(1, "t6b_wait_rready");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6b_arvalid",   64'(bus_if.arvalid),   64'd0);
        checkOutput("t6b_rready",    64'(bus_if.rready),    64'd0);
        checkOutput("t6b_out_valid", 64'(bus_if.out_valid), 64'd0);
        checkOutput("t6b_out_pc",    bus_if.out_pc,         64'h8000_0000);
        checkOutput("t6b_out_inst",  64'(bus_if.out_inst),  64'd0);
        checkOutput("t6b_out_fault", 64'(bus_if.out_fault), 64'd0);
        tick();
        rst    = 1'b0;
        rdelay = 0;
        clearObs();
        waitConsumes(1, "t6b_timeout");
        checkOutput("t6b_ar", qAt(obs_ar, 0), 64'h8000_0000);
        checkOutput("t6b_pc", qAt(obs_pc, 0), 64'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
